// File: rtl/prog_loader_if.sv
// prog_loader byte-stream and ROM write-port bundle.
// master = stream source / ROM side, slave = loader.
interface prog_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rom_wen;
  logic [15:0] rom_waddr;
  logic [15:0] rom_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  rom_wen,
    input  rom_waddr,
    input  rom_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output rom_wen,
    output rom_waddr,
    output rom_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: boot-time loader that writes a checksummed
// byte stream into instruction ROM and releases core reset.
module prog_loader #(
  parameter logic [15:0] BASE    = 16'h0000,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         core_reset_n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  word_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_WR,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] idle_q, idle_d;
  logic [15:0] idle_inc;

  logic        rdy;
  logic        acc;

  assign acc      = rdy && bus.rx_valid;
  assign idle_inc = idle_q + 16'd1;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      hi_q    <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      xor_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      hi_q    <= hi_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      idle_q  <= idle_d;
    end
  end

  // Next state: stream parsing, checksum and idle timeout
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    hi_d    = hi_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    idle_d  = '0;
    if (rdy && !acc) begin
      idle_d = idle_inc;
    end
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_HI;
          idx_d   = '0;
          cnt_d   = '0;
          xor_d   = '0;
        end
      end
      S_HDR_HI: begin
        if (acc) begin
          n_d[15:8] = bus.rx_data;
          state_d   = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (acc) begin
          n_d[7:0] = bus.rx_data;
          if ({n_q[15:8], bus.rx_data} != 16'd0) begin
            state_d = S_DAT_HI;
          end else begin
            state_d = S_CHK;
          end
        end
      end
      S_DAT_HI: begin
        if (acc) begin
          hi_d    = bus.rx_data;
          state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: begin
        if (acc) begin
          word_d  = {hi_q, bus.rx_data};
          state_d = S_WR;
        end
      end
      S_WR: begin
        idx_d = idx_q + 16'd1;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == n_q - 16'd1) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DAT_HI;
        end
      end
      S_CHK: begin
        if (acc) begin
          if (bus.rx_data == xor_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The checksum byte itself is not folded into the XOR
    if (acc && state_q != S_CHK) begin
      xor_d = xor_q ^ bus.rx_data;
    end
    if (rdy && !acc && idle_inc == TIMEOUT) begin
      state_d = S_ERR;
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    rdy           = 1'b0;
    bus.rom_wen   = 1'b0;
    bus.rom_waddr = '0;
    bus.rom_wdata = '0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    core_reset_n  = 1'b0;
    unique case (state_q)
      S_HDR_HI, S_HDR_LO,
      S_DAT_HI, S_DAT_LO, S_CHK: begin
        rdy  = 1'b1;
        busy = 1'b1;
      end
      S_WR: begin
        busy          = 1'b1;
        bus.rom_wen   = 1'b1;
        bus.rom_waddr = BASE + idx_q;
        bus.rom_wdata = word_q;
      end
      S_DONE: begin
        done         = 1'b1;
        core_reset_n = 1'b1;
      end
      S_ERR: err = 1'b1;
      default: ;
    endcase
  end

  assign bus.rx_ready = rdy;
  assign word_cnt     = cnt_q;

endmodule
